// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock controller.
//   state_t      : controller states
//   DIGIT_RANGE  : keycodes below this value are digits
//   *_KEY_DEF    : default special keycodes
package lock_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, LOCKOUT, PROG} state_t;

  localparam int DIGIT_RANGE   = 10;
  localparam int SET_KEY_DEF   = 13;
  localparam int ENTER_KEY_DEF = 14;
  localparam int CLEAR_KEY_DEF = 15;
endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry-timeout, open-window and
// lockout functions; only one of them runs at a time.
//   clk, rst : clock, async active-high reset
//   load     : load counter with value (wins over counting)
//   value    : reload value (cycles - 1)
//   expired  : counter has reached zero
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/comb_lock_ctrl.sv
// Combination-lock controller: consumes newkey/keycode strobes from the
// keypad scanner and drives the unlock / lockout / error outputs.
// Optional feature macro: COMB_LOCK_CODE_CHANGE_EN enables SET-key code
// programming from the OPEN state (PROG state + code register).
//   clk5    : clock          reset   : async active-high reset
//   newkey  : key strobe     keycode : key value
//   open    : lock released  lockout : lockout in progress
//   err     : 1-cycle pulse per rejected ENTER
//   digits  : digits entered so far
module comb_lock_ctrl
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter int          KEY_W          = 5,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int          ENTER_KEY      = ENTER_KEY_DEF,
  parameter int          CLEAR_KEY      = CLEAR_KEY_DEF,
  parameter int          SET_KEY        = SET_KEY_DEF,
  parameter int          MAX_FAIL       = 3,
  parameter int          OPEN_CYCLES    = 25_000_000,
  parameter int          LOCKOUT_CYCLES = 50_000_000,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                              clk5,
  input  logic                              reset,
  input  logic                              newkey,
  input  logic [KEY_W-1:0]                  keycode,
  output logic                              open,
  output logic                              lockout,
  output logic                              err,
  output logic [$clog2(CODE_LEN+1)-1:0]     digits
);
  localparam int DW   = $clog2(CODE_LEN+1);
  localparam int BW   = 4*CODE_LEN;
  localparam int FW   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL+1) : 1;
  localparam int MAXA = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t          state, nxt;
  logic [BW-1:0]   buffer;
  logic [BW-1:0]   code;
  logic            ovf;
  logic [FW-1:0]   fail_cnt;
  logic            expired, tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            is_digit, is_enter, is_clear;
  logic            match, lock_hit, enter_ok, reject;

  assign is_digit = 32'(keycode) < DIGIT_RANGE;
  assign is_enter = 32'(keycode) == ENTER_KEY;
  assign is_clear = 32'(keycode) == CLEAR_KEY;

`ifdef COMB_LOCK_CODE_CHANGE_EN
  logic          is_set;
  logic [BW-1:0] code_q;
  assign is_set = 32'(keycode) == SET_KEY;
  assign code   = code_q;
`else
  assign code   = DEFAULT_CODE[BW-1:0];
`endif

  assign match    = (digits == DW'(CODE_LEN)) && !ovf && (buffer == code);
  assign lock_hit = (32'(fail_cnt) + 1) >= MAX_FAIL;

  // Next-state decode. A key strobe always takes priority over timer
  // expiry; the expiry is then seen one cycle later.
  always_comb begin
    nxt      = state;
    enter_ok = 1'b0;
    reject   = 1'b0;
    case (state)
      IDLE: if (newkey) begin
        if (is_digit) nxt = ENTRY;
        else if (is_enter) begin
          reject = 1'b1;
          nxt    = lock_hit ? LOCKOUT : IDLE;
        end
      end
      ENTRY: begin
        if (newkey) begin
          if (is_clear) nxt = IDLE;
          else if (is_enter) begin
            if (match) begin
              nxt      = OPEN;
              enter_ok = 1'b1;
            end else begin
              reject = 1'b1;
              nxt    = lock_hit ? LOCKOUT : IDLE;
            end
          end
        end else if (expired) nxt = IDLE;
      end
      OPEN: begin
        if (newkey) begin
          if (is_clear) nxt = IDLE;
`ifdef COMB_LOCK_CODE_CHANGE_EN
          else if (is_set) nxt = PROG;
`endif
        end else if (expired) nxt = IDLE;
      end
      LOCKOUT: if (!newkey && expired) nxt = IDLE;
`ifdef COMB_LOCK_CODE_CHANGE_EN
      PROG: begin
        if (newkey) begin
          if (is_clear || is_enter) nxt = IDLE;
        end else if (expired) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Reload on every state change, and on each key while collecting digits
  // (any strobe counts as activity for the entry timeout).
  always_comb begin
    tmr_load = (nxt != state) || (newkey && (state == ENTRY || state == PROG));
    case (nxt)
      ENTRY:      tmr_val = TW'(TIMEOUT_CYCLES - 1);
      OPEN, PROG: tmr_val = TW'(OPEN_CYCLES - 1);
      LOCKOUT:    tmr_val = TW'(LOCKOUT_CYCLES - 1);
      default:    tmr_val = '0;
    endcase
  end

  lock_timer #(.W(TW)) u_timer (
    .clk     (clk5),
    .rst     (reset),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (expired)
  );

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      open     <= 1'b0;
      lockout  <= 1'b0;
      err      <= 1'b0;
      digits   <= '0;
      buffer   <= '0;
      ovf      <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state   <= nxt;
      open    <= (nxt == OPEN) || (nxt == PROG);
      lockout <= (nxt == LOCKOUT);
      err     <= reject;

      if (enter_ok)                                 fail_cnt <= '0;
      else if (reject)                              fail_cnt <= fail_cnt + 1'b1;
      else if (state == LOCKOUT && nxt == IDLE)     fail_cnt <= '0;

      // Buffer is only live while collecting digits; PROG reuses it for
      // the new code.
      if (nxt != ENTRY && nxt != PROG) begin
        buffer <= '0;
        digits <= '0;
        ovf    <= 1'b0;
      end else if (newkey && is_digit) begin
        if (digits < DW'(CODE_LEN)) begin
          buffer <= BW'({buffer, keycode[3:0]});
          digits <= digits + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

`ifdef COMB_LOCK_CODE_CHANGE_EN
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) code_q <= DEFAULT_CODE[BW-1:0];
    else if (state == PROG && newkey && is_enter &&
             digits == DW'(CODE_LEN) && !ovf)
      code_q <= buffer;
  end
`endif
endmodule

// File: doc/comb_lock_ctrl.md
# comb_lock_ctrl

Parametrised combination-lock controller that consumes the debounced `newkey`/`keycode` stream from the keypad scanner and drives the unlock output. It generalises the fixed lock core to configurable code length, timed open window, entry timeout and failed-attempt lockout. It sits between `keypad` and the top-level unlock/LED pins, on the 5 MHz domain.

## Interface
- `CODE_LEN`, 4: digits per code (1..8).
- `KEY_W`, 5: keycode width.
- `DEFAULT_CODE`, 32'h0000_1234: reset code, 4 bits per digit, digit 0 (first entered) in the most-significant used nibble; only the low `4*CODE_LEN` bits are used.
- `ENTER_KEY`, 14 / `CLEAR_KEY`, 15 / `SET_KEY`, 13: special keycodes.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1).
- `OPEN_CYCLES`, 25_000_000: open window length, in cycles.
- `LOCKOUT_CYCLES`, 50_000_000: lockout length, in cycles.
- `TIMEOUT_CYCLES`, 50_000_000: idle gap during entry before the entry is discarded.
- `clk5` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `newkey` in 1: one-cycle strobe per keypress.
- `keycode` in `KEY_W`: key value; valid when `newkey` is high.
- `open` out 1: lock released.
- `lockout` out 1: lockout in progress.
- `err` out 1: one-cycle pulse on each rejected ENTER.
- `digits` out `$clog2(CODE_LEN+1)`: count of digits entered so far (for the LED display).

## Operation
- Digit key: keycode 0–9. Keycodes 10–12, and any value ≥16 that is not a special key, are ignored in every state.
- IDLE: a digit goes to ENTRY (buffer ← digit, `digits`=1). ENTER with no digits counts as a failure. CLEAR does nothing.
- ENTRY:
  - A digit shifts into the buffer while `digits<CODE_LEN`. Further digits set an internal `ovf` flag; `digits` saturates.
  - CLEAR empties the buffer and returns to IDLE. It does not count as a failure.
  - ENTER is a match only if `digits==CODE_LEN`, `!ovf`, and buffer==code.
    - Match: go to OPEN and clear the fail counter.
    - Mismatch: pulse `err`, increment the fail counter, and return to IDLE. If the counter reaches `MAX_FAIL`, go to LOCKOUT instead.
  - Timeout: no `newkey` for `TIMEOUT_CYCLES` discards the entry and returns to IDLE. It does not count as a failure.
- OPEN: `open`=1 for `OPEN_CYCLES`, then IDLE. CLEAR relocks immediately. Other keys are ignored (except SET; see Configuration).
- LOCKOUT: `lockout`=1 and all keys are ignored. After `LOCKOUT_CYCLES`, go to IDLE with the fail counter cleared.
- Buffer and `ovf` are cleared on every entry to IDLE.
- Reset, including mid-operation, returns to IDLE: `open`=0, `lockout`=0, `err`=0, `digits`=0, fail counter 0, code=`DEFAULT_CODE`.

## Timing
- All outputs are registered.
- A key strobe at edge t is acted on at edge t. The resulting output changes are visible from t (after that edge) until the next change.
- ENTER-match strobe at edge t: `open` is high for exactly `OPEN_CYCLES` edges starting at t. `open` falls at t+`OPEN_CYCLES`.
- `err` is high for exactly the one cycle following a rejected ENTER.
- Timers reload on state entry. In ENTRY the timer also reloads on each accepted `newkey`.
- A timer expiring in the same cycle as a `newkey`: the key wins. The entry timeout is restarted; in OPEN the key is processed and the window ends next cycle; in LOCKOUT the key is ignored.
- Back-to-back `newkey` on consecutive cycles is each processed.

## Configuration
- `COMB_LOCK_CODE_CHANGE_EN` defined:
  - In OPEN, SET_KEY enters state PROG. `open` stays high and the timer restarts.
  - In PROG, digits fill a new-code buffer.
  - ENTER with exactly `CODE_LEN` digits writes the code register and goes to IDLE.
  - A wrong count, CLEAR, or timeout aborts to IDLE with the code unchanged.
- Undefined: SET_KEY is treated as an ignored key, there is no PROG state, and the code is the constant `DEFAULT_CODE` (no storage register).

## Structure
- Package `lock_pkg`: state enum (IDLE, ENTRY, OPEN, LOCKOUT, PROG), digit-range constant (10), default special-key codes.
- Sub-module `lock_timer`: single loadable down-counter with `load`, `value`, and `expired` ports, shared by the timeout, open and lockout functions (only one runs at a time). Width is `$clog2` of the largest cycle parameter.

## Test plan
Sim parameters: `CODE_LEN`=4, `DEFAULT_CODE`=16'h1234, `MAX_FAIL`=3, `OPEN_CYCLES`=50, `LOCKOUT_CYCLES`=100, `TIMEOUT_CYCLES`=200.

- Keys 1,2,3,4,ENTER → `open` rises at the ENTER edge, stays high 50 cycles, then 0; `digits` returns to 0.
- Keys 1,2,3,5,ENTER sent three times → `err` pulses 3 times; `lockout`=1 for 100 cycles. 1,2,3,4,ENTER during lockout → no `open`. After lockout, 1,2,3,4,ENTER → `open`.
- Keys 1,2,3,4,9,ENTER (overflow) → `err`, no `open`. Keys 1,2,CLEAR,1,2,3,4,ENTER → `open`, no `err`.
- Keys 1,2, then 200 idle cycles → `digits`=0; then 3,4,ENTER → `err`.
- Assert `reset` mid-OPEN at cycle 20 → `open`=0 immediately and asynchronously; all outputs reset.
- With the macro: unlock, SET,9,8,7,6,ENTER, then 1,2,3,4,ENTER → `err`; 9,8,7,6,ENTER → `open`. Without the macro: SET is ignored and 1,2,3,4 still opens.
